// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ requesters.
// Holds each grant for one packet, bounded by a burst limit and an idle timeout.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                      clk_master,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_busy, w_busy_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last_owner, w_last_owner_nxt;
  logic [3:0]         r_beat_cnt, w_beat_cnt_nxt;
  logic [7:0]         r_idle_cnt, w_idle_cnt_nxt;

  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;
  logic               w_own_valid;
  logic               w_own_last;
  logic               w_beat;
  logic               w_release;
  logic [DATA_W-1:0]  w_req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_beat      = fifo_wr_en;

  // Rotating priority: the requester just after the last owner is looked at first.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (r_state == S_GRANT) begin
      req_ready[r_owner] = !fifo_full;
      fifo_wr_en         = w_own_valid && !fifo_full;
      fifo_wr_data       = w_req_bytes[r_owner];
    end
  end

  // A full stall (valid but blocked) neither counts as a beat nor as idle.
  assign w_release = (r_state == S_GRANT) &&
                     ((w_beat && (w_own_last || r_beat_cnt == 4'(MAX_BURST - 1))) ||
                      (!w_own_valid && r_idle_cnt == 8'(TIMEOUT - 1)));

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_busy_nxt       = r_busy;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_idle_cnt_nxt   = r_idle_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_GRANT;
          w_grant_nxt    = NUM_REQ'(1) << w_winner;
          w_busy_nxt     = 1'b1;
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
          w_idle_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 4'd1;
          w_idle_cnt_nxt = '0;
        end else if (!w_own_valid && r_idle_cnt != 8'hFF) begin
          w_idle_cnt_nxt = r_idle_cnt + 8'd1;
        end
        if (w_release) begin
          w_state_nxt      = S_IDLE;
          w_grant_nxt      = '0;
          w_busy_nxt       = 1'b0;
          w_last_owner_nxt = r_owner;
          w_beat_cnt_nxt   = '0;
          w_idle_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_master) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
    end
  end

endmodule
